// File: rtl/centroid_pkg.sv
// Shared constants and FSM state type for the centroid accumulator.
// CENTROID_ACC_SAT_EN (optional) switches the frame sum from wrapping to saturating.
package centroid_pkg;

    localparam int DEFAULT_WIDTH       = 17;
    localparam int DEFAULT_COORD_WIDTH = 11;

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        ISSUE    = 2'd1,
        WAIT_DIV = 2'd2
    } state_t;

endpackage

// File: rtl/sat_accumulator.sv
// Running signed accumulator with optional saturation and a sticky clamp flag.
// The total output is combinational so a closing frame can include the current addend.
module sat_accumulator
    import centroid_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    add,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] addend,
    output logic signed [WIDTH-1:0] total,
    output logic                    sat_any
);

    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] acc;
    logic                    sat_seen;
    logic        [WIDTH:0]   wide;
    logic                    overflow;

    // One guard bit detects signed overflow; the guard bit's sign picks the clamp rail.
    always_comb begin
        wide     = {acc[WIDTH-1], acc} + (add ? {addend[WIDTH-1], addend} : {(WIDTH+1){1'b0}});
        overflow = (wide[WIDTH] != wide[WIDTH-1]);
        total    = wide[WIDTH-1:0];
        if (SATURATE && overflow) begin
            total = wide[WIDTH] ? MIN_VAL : MAX_VAL;
        end
        sat_any = sat_seen | (SATURATE && overflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sat_seen <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            sat_seen <= 1'b0;
        end else begin
            acc      <= total;
            sat_seen <= sat_any;
        end
    end

endmodule

// File: rtl/centroid_accumulator.sv
// Per-frame sum/count of masked pixel x offsets, handed to an external divider.
// Define CENTROID_ACC_SAT_EN to saturate the sum and report clamping on sat_out.
module centroid_accumulator
    import centroid_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pixel_valid_in,
    input  logic                          mask_in,
    input  logic signed [COORD_WIDTH-1:0] x_in,
    input  logic                          frame_end_in,
    input  logic                          div_done_in,
    output logic signed [WIDTH-1:0]       dividend_out,
    output logic signed [WIDTH-1:0]       divisor_out,
    output logic                          div_valid_out,
    output logic                          busy_out,
    output logic                          empty_out,
    output logic                          dropped_out,
    output logic                          sat_out
);

`ifdef CENTROID_ACC_SAT_EN
    localparam bit SUM_SATURATE = 1'b1;
`else
    localparam bit SUM_SATURATE = 1'b0;
`endif

    localparam logic signed [WIDTH-1:0] COUNT_STEP = WIDTH'(1);

    state_t                  state;
    state_t                  next_state;
    logic                    take;
    logic signed [WIDTH-1:0] x_ext;
    logic signed [WIDTH-1:0] sum_total;
    logic signed [WIDTH-1:0] count_total;
    logic                    sum_sat;
    logic                    count_sat_unused;
    logic                    frame_full;
    logic                    accept;
    logic                    drop;
    logic                    empty;

    assign take  = pixel_valid_in && mask_in;
    assign x_ext = {{(WIDTH-COORD_WIDTH){x_in[COORD_WIDTH-1]}}, x_in};

    // Accumulators run regardless of FSM state; frame_end always starts a fresh frame.
    sat_accumulator #(
        .WIDTH    (WIDTH),
        .SATURATE (SUM_SATURATE)
    ) sum_acc (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .add     (take),
        .clear   (frame_end_in),
        .addend  (x_ext),
        .total   (sum_total),
        .sat_any (sum_sat)
    );

    sat_accumulator #(
        .WIDTH    (WIDTH),
        .SATURATE (1'b1)
    ) count_acc (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .add     (take),
        .clear   (frame_end_in),
        .addend  (COUNT_STEP),
        .total   (count_total),
        .sat_any (count_sat_unused)
    );

    assign frame_full = frame_end_in && (count_total != '0);
    assign empty      = frame_end_in && (count_total == '0);
    assign accept     = frame_full && ((state == ACCUM) || ((state == WAIT_DIV) && div_done_in));
    assign drop       = frame_full && !accept;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM: begin
                if (accept) next_state = ISSUE;
            end
            ISSUE: begin
                next_state = WAIT_DIV;
            end
            WAIT_DIV: begin
                if (accept) begin
                    next_state = ISSUE;
                end else if (div_done_in) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    always_comb begin
        div_valid_out = (state == ISSUE);
        busy_out      = (state != ACCUM);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dividend_out <= '0;
            divisor_out  <= '0;
            empty_out    <= 1'b0;
            dropped_out  <= 1'b0;
        end else begin
            empty_out   <= empty;
            dropped_out <= drop;
            if (accept) begin
                dividend_out <= sum_total;
                divisor_out  <= count_total;
            end
        end
    end

`ifdef CENTROID_ACC_SAT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sat_out <= 1'b0;
        end else if (accept) begin
            sat_out <= sum_sat;
        end
    end
`else
    logic sum_sat_unused;
    assign sum_sat_unused = sum_sat;
    assign sat_out        = 1'b0;
`endif

endmodule

// File: tb/tb_centroid_accumulator.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// randomized traffic compared against a frame-level arithmetic model.
module tb_centroid_accumulator;

    localparam int  W    = 17;
    localparam int  CW   = 11;
    localparam longint MAXV = 65535;
    localparam longint MINV = -65536;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b0;
    logic                 pixel_valid_in = 1'b0;
    logic                 mask_in = 1'b0;
    logic signed [CW-1:0] x_in = '0;
    logic                 frame_end_in = 1'b0;
    logic                 div_done_in = 1'b0;
    logic signed [W-1:0]  dividend_out;
    logic signed [W-1:0]  divisor_out;
    logic                 div_valid_out;
    logic                 busy_out;
    logic                 empty_out;
    logic                 dropped_out;
    logic                 sat_out;

    int tests    = 0;
    int failures = 0;

    centroid_accumulator #(.WIDTH(W), .COORD_WIDTH(CW)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .pixel_valid_in (pixel_valid_in),
        .mask_in        (mask_in),
        .x_in           (x_in),
        .frame_end_in   (frame_end_in),
        .div_done_in    (div_done_in),
        .dividend_out   (dividend_out),
        .divisor_out    (divisor_out),
        .div_valid_out  (div_valid_out),
        .busy_out       (busy_out),
        .empty_out      (empty_out),
        .dropped_out    (dropped_out),
        .sat_out        (sat_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit  pv;
        bit  mask;
        int  x;
        bit  fe;
        bit  dd;
        int  dividend;
        int  divisor;
        bit  valid;
        bit  busy;
        bit  empty;
        bit  drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit pv, bit mask, int x, bit fe, bit dd,
                                int dividend, int divisor, bit valid, bit busy, bit empty, bit drop);
        vec_t v;
        v = '{pv, mask, x, fe, dd, dividend, divisor, valid, busy, empty, drop};
        return v;
    endfunction

    // Model state: exact frame arithmetic plus whether a division is issuing/outstanding
    longint m_sum, m_cnt, e_div, e_dvs;
    bit     m_sat, m_issue, m_wait, e_sat, e_empty, e_drop;

    function automatic longint wrap(longint v);
        longint r;
        r = v & 64'h1FFFF;
        if (r > MAXV) r = r - 131072;
        return r;
    endfunction

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_sat = 0; m_issue = 0; m_wait = 0;
        e_div = 0; e_dvs = 0; e_sat = 0; e_empty = 0; e_drop = 0;
    endtask

    task automatic model_step(bit pv, bit m, int x, bit fe, bit dd);
        longint ns, nc;
        bit nsat, acc, was_issue, was_wait;
        ns = m_sum; nc = m_cnt; nsat = m_sat;
        was_issue = m_issue; was_wait = m_wait;
        if (pv && m) begin
            ns = m_sum + x;
            nc = (m_cnt + 1 > MAXV) ? MAXV : m_cnt + 1;
`ifdef CENTROID_ACC_SAT_EN
            if (ns > MAXV) begin ns = MAXV; nsat = 1; end
            else if (ns < MINV) begin ns = MINV; nsat = 1; end
`else
            ns = wrap(ns);
`endif
        end
        e_empty = fe && (nc == 0);
        acc     = fe && (nc > 0) && ((!was_issue && !was_wait) || (was_wait && dd));
        e_drop  = fe && (nc > 0) && !acc;
        if (acc) begin
            e_div = ns; e_dvs = nc; e_sat = nsat;
        end
        m_issue = acc;
        m_wait  = was_issue || (was_wait && !dd && !acc);
        if (fe) begin
            m_sum = 0; m_cnt = 0; m_sat = 0;
        end else begin
            m_sum = ns; m_cnt = nc; m_sat = nsat;
        end
    endtask

    task automatic applyStimulus(bit pv, bit m, int x, bit fe, bit dd);
        pixel_valid_in = pv;
        mask_in        = m;
        x_in           = x[CW-1:0];
        frame_end_in   = fe;
        div_done_in    = dd;
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(string name, longint actual, longint expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(string tag, longint dv, longint ds, bit valid, bit busy,
                             bit empty, bit drop, bit sat);
        checkOutput({tag, ".dividend"}, dividend_out, dv);
        checkOutput({tag, ".divisor"},  divisor_out,  ds);
        checkOutput({tag, ".div_valid"}, div_valid_out, valid);
        checkOutput({tag, ".busy"},     busy_out,     busy);
        checkOutput({tag, ".empty"},    empty_out,    empty);
        checkOutput({tag, ".dropped"},  dropped_out,  drop);
        checkOutput({tag, ".sat"},      sat_out,      sat);
    endtask

    initial begin
        bit exp_sat;
        longint exp_div;
        bit r_pv, r_m, r_fe, r_dd;
        int r_x;

        // Power-up reset
        #2;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // Basic frame, negative frame, empty frame, drops and same-cycle done/end
        vecs.push_back(mk(1,1,  10,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,0, 500,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,1,  20,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,0,  -7,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,0,   3,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,1,  30,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,0,   1,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(1,0,   2,0,0,    0,0,0,0,0,0));
        vecs.push_back(mk(0,0,   0,1,0,   60,3,1,1,0,0));
        vecs.push_back(mk(0,0,   0,0,0,   60,3,0,1,0,0));
        vecs.push_back(mk(0,0,   0,0,0,   60,3,0,1,0,0));
        vecs.push_back(mk(0,0,   0,0,1,   60,3,0,0,0,0));
        vecs.push_back(mk(0,0,   0,0,1,   60,3,0,0,0,0));
        vecs.push_back(mk(1,1,-100,0,0,   60,3,0,0,0,0));
        vecs.push_back(mk(1,1,-100,0,0,   60,3,0,0,0,0));
        vecs.push_back(mk(1,1,-100,0,0,   60,3,0,0,0,0));
        vecs.push_back(mk(0,0,   0,1,0, -300,3,1,1,0,0));
        vecs.push_back(mk(0,0,   0,0,1, -300,3,0,1,0,0));
        vecs.push_back(mk(0,0,   0,0,1, -300,3,0,0,0,0));
        vecs.push_back(mk(1,0,  77,1,0, -300,3,0,0,1,0));
        vecs.push_back(mk(0,0,   0,0,0, -300,3,0,0,0,0));
        vecs.push_back(mk(1,1,   5,0,0, -300,3,0,0,0,0));
        vecs.push_back(mk(0,0,   0,1,0,    5,1,1,1,0,0));
        vecs.push_back(mk(1,1,   7,0,0,    5,1,0,1,0,0));
        vecs.push_back(mk(1,0,   0,1,0,    5,1,0,1,0,1));
        vecs.push_back(mk(1,1,   9,0,0,    5,1,0,1,0,0));
        vecs.push_back(mk(1,1,   4,1,1,   13,2,1,1,0,0));
        vecs.push_back(mk(0,0,   0,0,1,   13,2,0,1,0,0));
        vecs.push_back(mk(0,0,   0,0,1,   13,2,0,0,0,0));
        vecs.push_back(mk(1,1,   1,0,0,   13,2,0,0,0,0));
        vecs.push_back(mk(0,0,   0,1,0,    1,1,1,1,0,0));
        vecs.push_back(mk(1,1,   2,1,0,    1,1,0,1,0,1));
        vecs.push_back(mk(0,0,   0,0,1,    1,1,0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pv, vecs[i].mask, vecs[i].x, vecs[i].fe, vecs[i].dd);
            check_all($sformatf("vec%0d", i), vecs[i].dividend, vecs[i].divisor,
                      vecs[i].valid, vecs[i].busy, vecs[i].empty, vecs[i].drop, 1'b0);
        end

        // Reset asserted mid-division with a partially accumulated frame
        applyStimulus(1,1,50,0,0);
        applyStimulus(1,1,50,1,0);
        check_all("pre_rst", 100, 2, 1, 1, 0, 0, 0);
        applyStimulus(1,1,9,0,0);
        #3;
        rst_in = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0,0,0,0,0);
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0,0,0,0,1);
            check_all("post_rst", 0, 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(0,0,0,1,0);
        check_all("post_rst_empty", 0, 0, 0, 0, 1, 0, 0);

        // Overflow: 200 pixels at the largest x
        for (int i = 0; i < 200; i++) applyStimulus(1,1,1023,0,0);
        applyStimulus(0,0,0,1,0);
`ifdef CENTROID_ACC_SAT_EN
        exp_div = 65535; exp_sat = 1'b1;
`else
        exp_div = -57544; exp_sat = 1'b0;
`endif
        check_all("overflow", exp_div, 200, 1, 1, 0, 0, exp_sat);
        applyStimulus(0,0,0,0,1);
        applyStimulus(0,0,0,0,1);
        check_all("overflow_done", exp_div, 200, 0, 0, 0, 0, exp_sat);

        // Randomized traffic against the model, starting from a clean reset
        rst_in = 1'b0;
        applyStimulus(0,0,0,0,0);
        rst_in = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            r_pv = ($urandom % 4) != 0;
            r_m  = ($urandom % 2) != 0;
            r_x  = int'($urandom_range(2047)) - 1024;
            r_fe = ($urandom % 10) == 0;
            r_dd = ($urandom % 4) == 0;
            applyStimulus(r_pv, r_m, r_x, r_fe, r_dd);
            model_step(r_pv, r_m, r_x, r_fe, r_dd);
            check_all($sformatf("rand%0d", i), e_div, e_dvs, m_issue, m_issue || m_wait,
                      e_empty, e_drop, e_sat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/centroid_accumulator.md
CENTROID_ACCUMULATOR -- requirements
Module: centroid_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 17: signed width of the dividend/divisor handed to the divider.
REQ-002 SHALL have parameter COORD_WIDTH, default 11: signed width of the pixel x offset.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port pixel_valid_in, input, 1, a pixel is present this cycle.
REQ-006 SHALL have port mask_in, input, 1, the present pixel belongs to the tracked object.
REQ-007 SHALL have port x_in, input, COORD_WIDTH signed, the pixel x offset from image centre.
REQ-008 SHALL have port frame_end_in, input, 1, one-cycle pulse closing the current frame.
REQ-009 SHALL have port div_done_in, input, 1, driven by the divider's data_valid_out.
REQ-010 SHALL have port dividend_out, output, WIDTH signed, the frame sum of masked x.
REQ-011 SHALL have port divisor_out, output, WIDTH signed, the masked pixel count; always at least 0.
REQ-012 SHALL have port div_valid_out, output, 1, the divider's data_valid_in; a one-cycle pulse.
REQ-013 SHALL have port busy_out, output, 1, high while a division is outstanding.
REQ-014 SHALL have ports empty_out, dropped_out and sat_out, outputs, 1 each, status pulses or flags.

Function
REQ-015 SHALL have states ACCUM, ISSUE and WAIT_DIV; the running accumulators work independently of the state (double-buffered).
REQ-016 SHALL, on pixel_valid_in && mask_in, add sign-extended x_in to the running sum and add 1 to the running count.
REQ-017 SHALL, when frame_end_in coincides with an accepted pixel, include that pixel in the closing frame.
REQ-018 SHALL, on frame_end_in with count 0, issue nothing, pulse empty_out for 1 cycle, clear the accumulators and keep the state.
REQ-019 SHALL, on frame_end_in with count above 0 and state ACCUM, latch the sum and count into dividend_out/divisor_out, clear the accumulators and enter ISSUE.
REQ-020 SHALL, in ISSUE, assert div_valid_out for exactly 1 cycle (the cycle after frame_end_in) and then enter WAIT_DIV.
REQ-021 SHALL hold busy_out high in ISSUE and WAIT_DIV, and keep dividend_out/divisor_out stable until the state leaves WAIT_DIV.
REQ-022 SHALL, in WAIT_DIV, return to ACCUM on div_done_in.
REQ-023 SHALL, on a non-empty frame_end_in in ISSUE or in WAIT_DIV without div_done_in, drop the frame: pulse dropped_out for 1 cycle, clear the accumulators, leave the outputs unchanged.
REQ-024 SHALL, when div_done_in and a non-empty frame_end_in coincide in WAIT_DIV, accept the new frame and go directly to ISSUE.
REQ-025 SHALL ignore div_done_in in ACCUM and ISSUE.
REQ-026 SHALL saturate count at 2^(WIDTH-1)-1.

Reset
REQ-027 SHALL, while rst_in is low, immediately clear all outputs, accumulators and flags to 0 and force state ACCUM, including mid-frame and mid-division.
REQ-028 SHALL discard any frame or outstanding division that was interrupted by reset.

Configuration
REQ-029 SHALL, with CENTROID_ACC_SAT_EN defined, clamp the sum to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set sat_out for the frame being issued if any clamp occurred.
REQ-030 SHALL, without CENTROID_ACC_SAT_EN, wrap the sum in two's complement at WIDTH bits and tie sat_out to 0.

Structure
REQ-031 SHALL take the state enum and the default WIDTH/COORD_WIDTH constants from package centroid_pkg.
REQ-032 SHALL implement the sum and count update in one sub-module, sat_accumulator, instanced twice (sum and count).

Verification
REQ-033 SHALL cover reset: rst_in low mid-frame -> all outputs 0, state ACCUM, no div_valid_out after release.
REQ-034 SHALL cover a basic frame: masked x=10, 20, 30 plus 5 unmasked pixels, then frame_end -> next cycle div_valid_out for 1 cycle, dividend 60, divisor 3, busy_out high until div_done_in.
REQ-035 SHALL cover a negative frame: masked x=-100 three times -> dividend -300, divisor 3.
REQ-036 SHALL cover an empty frame: frame_end with no masked pixels -> empty_out pulse, no div_valid_out.
REQ-037 SHALL cover a drop: frame_end in WAIT_DIV -> dropped_out pulse, outputs unchanged; same-cycle div_done_in and frame_end -> new frame issued.
REQ-038 SHALL cover overflow: 200 masked pixels at x=1023 -> with CENTROID_ACC_SAT_EN, dividend 65535 and sat_out=1; without it, dividend -57544.
